conv_y_requant: RTL and testbench



---
 rtl/conv_pkg.sv | 35 +++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/conv_y_requant.sv | 109 ++++++++++
 tb/tb_conv_y_requant.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : conv_pkg                                                       |
// | Purpose   : Shared helpers for the convolution output path: number of      |
// |             outputs per convolution vector, signed saturation bounds and   |
// |             the {last, data} FIFO entry layout.                            |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package conv_pkg;

  localparam int DEF_OUT_WIDTH = 8;

  // Valid-mode 1-D convolution output count.
  function automatic int num_out(input int x_size, input int f_size);
    return x_size - f_size + 1;
  endfunction

  function automatic longint sat_max(input int width);
    return (longint'(1) << (width - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int width);
    return -(longint'(1) << (width - 1));
  endfunction

  localparam longint SAT_MAX = sat_max(DEF_OUT_WIDTH);
  localparam longint SAT_MIN = sat_min(DEF_OUT_WIDTH);

  typedef struct packed {
    logic                            last;
    logic signed [DEF_OUT_WIDTH-1:0] data;
  } z_entry_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : sync_fifo                                                      |
// | Purpose   : Single-clock FIFO, DEPTH entries of WIDTH bits. Head entry is  |
// |             presented combinationally on rd_data.                          |
// | Ports     : clk, reset (sync, active-high), push/wr_data, pop/rd_data,     |
// |             full, empty, count (0..DEPTH).                                 |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage has no reset; only occupancy tracking is cleared.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_y_requant.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : conv_y_requant                                                 |
// | Purpose   : Requantises the signed Y accumulator stream to OUT_WIDTH-bit   |
// |             signed Z: round-half-up right shift, optional ReLU, saturate.  |
// |             Results are buffered in a FIFO and the last output of every    |
// |             convolution vector is tagged.                                  |
// | Ports     : clk, reset (sync, active-high)                                 |
// |             s_valid_y / s_ready_y / s_data_in_y / cfg_relu_en  (input Y)   |
// |             m_valid_z / m_ready_z / m_data_out_z / m_last_z   (output Z)   |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module conv_y_requant
  import conv_pkg::*;
#(
  parameter int ACC_SIZE  = 18,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT     = 7,
  parameter int X_SIZE    = 8,
  parameter int F_SIZE    = 4,
  parameter int DEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_valid_y,
  output logic                        s_ready_y,
  input  logic signed [ACC_SIZE-1:0]  s_data_in_y,
  input  logic                        cfg_relu_en,
  output logic                        m_valid_z,
  input  logic                        m_ready_z,
  output logic signed [OUT_WIDTH-1:0] m_data_out_z,
  output logic                        m_last_z
);

  localparam int NUM_OUT = num_out(X_SIZE, F_SIZE);
  localparam int LCW     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int EW      = OUT_WIDTH + 1;
  localparam int RW      = ACC_SIZE + 1;

  // (1 << SHIFT) >> 1 yields 2^(SHIFT-1), and 0 when SHIFT is 0.
  localparam logic signed [RW-1:0] ROUND = RW'((longint'(1) << SHIFT) >> 1);
  localparam logic signed [RW-1:0] Z_MAX = RW'(sat_max(OUT_WIDTH));
  localparam logic signed [RW-1:0] Z_MIN = RW'(sat_min(OUT_WIDTH));

  logic signed [RW-1:0]        y_ext;
  logic signed [RW-1:0]        y_rnd;
  logic signed [RW-1:0]        r_shift;
  logic signed [RW-1:0]        r_relu;
  logic signed [OUT_WIDTH-1:0] z;
  logic                        push;
  logic                        pop;
  logic [LCW-1:0]              last_cnt;
  logic                        push_last;
  logic [EW-1:0]               head;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [CW-1:0]               fifo_count;

  // One guard bit keeps y + rounding term from overflowing.
  always_comb begin
    y_ext   = {s_data_in_y[ACC_SIZE-1], s_data_in_y};
    y_rnd   = y_ext + ROUND;
    r_shift = y_rnd >>> SHIFT;
    r_relu  = (cfg_relu_en && (r_shift < 0)) ? '0 : r_shift;
    if (r_relu > Z_MAX) begin
      z = Z_MAX[OUT_WIDTH-1:0];
    end else if (r_relu < Z_MIN) begin
      z = Z_MIN[OUT_WIDTH-1:0];
    end else begin
      z = r_relu[OUT_WIDTH-1:0];
    end
  end

  assign push      = s_valid_y && s_ready_y;
  assign pop       = m_valid_z && m_ready_z;
  assign push_last = (last_cnt == LCW'(NUM_OUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      last_cnt <= '0;
    end else if (push) begin
      last_cnt <= push_last ? '0 : last_cnt + LCW'(1);
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data ({push_last, z}),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Ready depends only on occupancy, never on m_ready_z.
  assign s_ready_y    = !fifo_full;
  assign m_valid_z    = (fifo_count != '0);
  assign m_data_out_z = fifo_empty ? '0   : head[OUT_WIDTH-1:0];
  assign m_last_z     = fifo_empty ? 1'b0 : head[EW-1];

endmodule
`default_nettype wire

// File: tb/tb_conv_y_requant.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_conv_y_requant                                              |
// | Purpose   : Self-checking bench for conv_y_requant with a scoreboard of    |
// |             hand-computed expected Z values and last tags.                 |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_conv_y_requant;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               s_valid_y = 1'b0;
  logic               s_ready_y;
  logic signed [17:0] s_data_in_y = '0;
  logic               cfg_relu_en = 1'b0;
  logic               m_valid_z;
  logic               m_ready_z = 1'b0;
  logic signed [7:0]  m_data_out_z;
  logic               m_last_z;

  conv_y_requant dut (
    .clk          (clk),
    .reset        (reset),
    .s_valid_y    (s_valid_y),
    .s_ready_y    (s_ready_y),
    .s_data_in_y  (s_data_in_y),
    .cfg_relu_en  (cfg_relu_en),
    .m_valid_z    (m_valid_z),
    .m_ready_z    (m_ready_z),
    .m_data_out_z (m_data_out_z),
    .m_last_z     (m_last_z)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              last;
    logic signed [7:0] z;
  } exp_t;

  exp_t              sb[$];
  int                checks = 0;
  int                fails = 0;
  int                model_last = 0;
  int                pushed = 0;
  int                popped = 0;
  int                discarded = 0;
  int                last_seen = 0;
  logic signed [7:0] cur_exp = '0;
  logic              rand_done = 1'b0;

  // Directed vectors: y, relu, hand-computed z.
  localparam int NV = 18;
  int tv_y    [NV] = '{63, 64, 1000, -1000, 20000, -20000, -1000, 1000, -20000,
                       -64, -65, 16256, 16320, -16384, -16448, -16449, 131071, -131072};
  int tv_relu [NV] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
  int tv_z    [NV] = '{0, 1, 8, -8, 127, -128, 0, 8, 0, 0, -1, 127, 127, -128, -128, -128, 127, 0};

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor / scoreboard: state seen at negedge is what the next posedge acts on.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      discarded += sb.size();
      sb.delete();
      model_last = 0;
    end else begin
      check("s_ready_vs_occupancy", int'(s_ready_y), int'(sb.size() < 4));
      check("m_valid_vs_occupancy", int'(m_valid_z), int'(sb.size() != 0));
      if (sb.size() == 0) begin
        check("empty_data_zero", int'(m_data_out_z), 0);
        check("empty_last_zero", int'(m_last_z), 0);
      end
      if (m_valid_z && m_ready_z) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_output: got z=%0d, expected none", m_data_out_z);
        end else begin
          e = sb.pop_front();
          check("z_data", int'(m_data_out_z), int'(e.z));
          check("z_last", int'(m_last_z), int'(e.last));
        end
        if (m_last_z) last_seen++;
        popped++;
      end
      if (s_valid_y && s_ready_y) begin
        e.z    = cur_exp;
        e.last = (model_last == 4);
        model_last = (model_last == 4) ? 0 : model_last + 1;
        sb.push_back(e);
        pushed++;
      end
    end
  end

  task automatic push_y(input int y, input int relu, input int z);
    bit ok = 1'b0;
    s_valid_y   = 1'b1;
    s_data_in_y = 18'(y);
    cfg_relu_en = relu[0];
    cur_exp     = 8'(z);
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (s_ready_y) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL push_timeout: got s_ready_y=0, expected 1 within 1000 cycles");
    end
    @(posedge clk);
    #1 s_valid_y = 1'b0;
  endtask

  task automatic do_reset();
    s_valid_y = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    #1 reset  = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    m_ready_z = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !m_valid_z) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout: got %0d entries left, expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_m_valid", int'(m_valid_z), 0);
    check("reset_s_ready", int'(s_ready_y), 1);
    check("reset_data", int'(m_data_out_z), 0);
    check("reset_last", int'(m_last_z), 0);
    @(posedge clk);
    #1;

    // Isolated samples with ready held high: visible one cycle after push.
    m_ready_z = 1'b1;
    for (int i = 0; i < 9; i++) begin
      push_y(tv_y[i], tv_relu[i], tv_z[i]);
      @(negedge clk);
      check("latency_one_cycle", int'(m_valid_z), 1);
      @(posedge clk);
      #1;
    end

    // Boundary rounding/saturation vectors back to back.
    for (int i = 9; i < NV; i++) push_y(tv_y[i], tv_relu[i], tv_z[i]);
    drain();

    // Last tagging over two full vectors from a clean counter.
    do_reset();
    last_seen = 0;
    for (int i = 0; i < 10; i++) push_y(tv_y[i % NV], tv_relu[i % NV], tv_z[i % NV]);
    drain();
    check("last_count_10", last_seen, 2);

    // Backpressure: four fit, fifth and sixth wait until ready is released.
    m_ready_z = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) push_y(tv_y[i], tv_relu[i], tv_z[i]);
      end
      begin
        repeat (8) @(negedge clk);
        check("bp_s_ready_low", int'(s_ready_y), 0);
        check("bp_m_valid_held", int'(m_valid_z), 1);
        check("bp_head_data", int'(m_data_out_z), tv_z[0]);
        @(posedge clk);
        #1 m_ready_z = 1'b1;
      end
    join
    drain();

    // Random downstream readiness over 200 samples.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) push_y(tv_y[i % NV], tv_relu[i % NV], tv_z[i % NV]);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 m_ready_z = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    // Reset with three entries buffered and last counter at 3.
    do_reset();
    m_ready_z = 1'b0;
    for (int i = 0; i < 3; i++) push_y(tv_y[i], tv_relu[i], tv_z[i]);
    do_reset();
    @(negedge clk);
    check("mid_reset_m_valid", int'(m_valid_z), 0);
    check("mid_reset_s_ready", int'(s_ready_y), 1);
    @(posedge clk);
    #1;
    m_ready_z = 1'b1;
    last_seen = 0;
    for (int i = 0; i < 5; i++) push_y(tv_y[i], tv_relu[i], tv_z[i]);
    drain();
    check("post_reset_last_once", last_seen, 1);

    check("no_loss_or_dup", popped + discarded, pushed);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
`default_nettype wire
